// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1-style slice through an N-term multiply-accumulate.
// Optional ABORT input is compiled in with `define MAC_ABORT_EN.
module dsp_mac_sequencer #(
  parameter int CNT_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  input  logic             OP_VALID,
`ifdef MAC_ABORT_EN
  input  logic             ABORT,
`endif
  output logic             OP_READY,
  output logic             CE_PIPE,
  output logic [7:0]       OPMODE,
  output logic             BUSY,
  output logic             P_VALID
);

  // Handshake: an operand pair is consumed on a rising edge where OP_VALID
  // and OP_READY are both high; OP_VALID may drop at any time (stall).
  localparam int DW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [DW-1:0]       drn_q, drn_d;
  logic [PIPE_LAT-1:0] tv_q, tv_d, tf_q, tf_d, tl_q, tl_d;
  logic                p_valid_q, p_valid_d;
  logic                push_v, push_f, push_l;
  logic                abort;

`ifdef MAC_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    drn_d     = drn_q;
    tv_d      = tv_q;
    tf_d      = tf_q;
    tl_d      = tl_q;
    p_valid_d = 1'b0;
    push_v    = 1'b0;
    push_f    = 1'b0;
    push_l    = 1'b0;
    OP_READY  = 1'b0;
    CE_PIPE   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START && (LEN != '0)) begin
          state_d = S_FEED;
          len_d   = LEN;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        OP_READY = 1'b1;
        CE_PIPE  = OP_VALID;
        if (OP_VALID) begin
          push_v = 1'b1;
          push_f = (cnt_q == '0);
          push_l = (cnt_q == len_q - CNT_W'(1));
          cnt_d  = cnt_q + CNT_W'(1);
          if (push_l) begin
            state_d = S_DRAIN;
            drn_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        CE_PIPE = 1'b1;
        drn_d   = drn_q + DW'(1);
        if (drn_q == DW'(PIPE_LAT - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Tokens move in lockstep with the slice registers; P_VALID follows the
    // edge that loads the last term into P.
    if (CE_PIPE) begin
      p_valid_d = tv_q[PIPE_LAT-1] & tl_q[PIPE_LAT-1];
      tv_d      = {tv_q[PIPE_LAT-2:0], push_v};
      tf_d      = {tf_q[PIPE_LAT-2:0], push_f};
      tl_d      = {tl_q[PIPE_LAT-2:0], push_l};
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      CE_PIPE   = 1'b0;
      cnt_d     = '0;
      drn_d     = '0;
      tv_d      = '0;
      tf_d      = '0;
      tl_d      = '0;
      p_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      drn_q     <= '0;
      tv_q      <= '0;
      tf_q      <= '0;
      tl_q      <= '0;
      p_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      drn_q     <= drn_d;
      tv_q      <= tv_d;
      tf_q      <= tf_d;
      tl_q      <= tl_d;
      p_valid_q <= p_valid_d;
    end
  end

  // A bubble holds P, so leftovers from an earlier command never leak in.
  always_comb begin
    if (!tv_q[PIPE_LAT-1])     OPMODE = 8'h08;
    else if (tf_q[PIPE_LAT-1]) OPMODE = 8'h01;
    else                       OPMODE = 8'h09;
  end

  assign BUSY    = (state_q != S_IDLE) | p_valid_q;
  assign P_VALID = p_valid_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a cycle-timeline reference model plus a
// behavioural slice whose P register is checked against expected dot products.
module tb_dsp_mac_sequencer;
  localparam int CNT_W    = 8;
  localparam int PIPE_LAT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             op_valid = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       op_a = '0, op_b = '0;
  logic             op_ready, ce_pipe, busy, p_valid;
  logic [7:0]       opmode;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dsp_mac_sequencer #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK(clk),
    .RST(rst),
    .START(start),
    .LEN(len),
    .OP_VALID(op_valid),
`ifdef MAC_ABORT_EN
    .ABORT(abort),
`endif
    .OP_READY(op_ready),
    .CE_PIPE(ce_pipe),
    .OPMODE(opmode),
    .BUSY(busy),
    .P_VALID(p_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model (command timeline) ----------------
  logic [31:0] exp_q[$];
  bit          m_active = 1'b0;
  int          m_len = 0;
  int          m_cnt = 0;
  logic [31:0] m_sum = '0;
  int          m_pv_cyc = -1;

  always @(posedge clk) begin
    if (!rst) begin
      if (abort && m_active) begin
        if (m_cnt == m_len && exp_q.size() > 0) void'(exp_q.pop_back());
        m_active = 1'b0;
        m_pv_cyc = -1;
      end else if (m_active) begin
        if (m_cnt < m_len && op_valid) begin
          m_sum = m_sum + 32'(op_a) * 32'(op_b);
          m_cnt++;
          if (m_cnt == m_len) begin
            m_pv_cyc = cyc + PIPE_LAT + 1;
            exp_q.push_back(m_sum);
          end
        end
        if (m_cnt == m_len && cyc + 1 == m_pv_cyc) m_active = 1'b0;
      end else if (start && len != '0) begin
        m_active = 1'b1;
        m_len    = int'(len);
        m_cnt    = 0;
        m_sum    = '0;
      end
    end
    cyc++;
  end

  // ---------------- behavioural slice ----------------
  logic [15:0] m_pipe [PIPE_LAT];
  logic [31:0] slice_p = '0;
  logic        s_ce = 1'b0;
  logic [7:0]  s_op = 8'h08;

  always @(posedge clk) begin
    if (s_ce) begin
      case (s_op)
        8'h01:   slice_p = 32'(m_pipe[PIPE_LAT-1]);
        8'h09:   slice_p = slice_p + 32'(m_pipe[PIPE_LAT-1]);
        8'h08:   ;
        default: slice_p = 32'hDEAD_BEEF;
      endcase
      for (int i = PIPE_LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = 16'(op_a) * 16'(op_b);
    end
  end

  // ---------------- scoreboard / per-cycle monitor ----------------
  always @(negedge clk) begin
    bit feeding, e_pv, e_ce;
    logic [31:0] e;
    #2;
    s_ce = ce_pipe;
    s_op = opmode;
    if (!rst) begin
      feeding = m_active && (m_cnt < m_len);
      e_pv    = (cyc == m_pv_cyc);
      e_ce    = ((feeding && op_valid) || (m_active && !feeding)) && !(abort && m_active);
      check("op_ready", op_ready, feeding);
      check("ce_pipe", ce_pipe, e_ce);
      check("busy", busy, m_active || e_pv);
      check("p_valid", p_valid, e_pv);
      if (e_pv && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("p_sum", slice_p, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int l);
    start = 1'b1;
    len   = CNT_W'(l);
    @(negedge clk);
    start = 1'b0;
    len   = CNT_W'($urandom);
  endtask

  task automatic feed(input int stall_pct, input logic [31:0] mask, input bit use_mask);
    for (int k = 0; k < 2000 && m_active && m_cnt < m_len; k++) begin
      op_a     = 8'($urandom);
      op_b     = 8'($urandom);
      op_valid = use_mask ? !(k < 32 && mask[k]) : ($urandom_range(99) >= stall_pct);
      start    = ($urandom_range(9) == 0);
      len      = CNT_W'($urandom_range(1, 5));
      @(negedge clk);
    end
    op_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 300 && (m_active || cyc <= m_pv_cyc); k++) @(negedge clk);
    check("done_timeout", (k >= 300), 1'b0);
  endtask

  task automatic run_cmd(input int l, input int stall_pct, input logic [31:0] mask, input bit use_mask);
    pulse_start(l);
    feed(stall_pct, mask, use_mask);
    wait_done();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_op_ready"}, op_ready, 1'b0);
    check({tag, "_ce_pipe"}, ce_pipe, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_p_valid"}, p_valid, 1'b0);
    check({tag, "_opmode"}, opmode, 8'h08);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // basic LEN=3, operands always valid
    run_cmd(3, 0, 32'h0, 1'b1);
    // LEN=4 with stalls in the 2nd and 4th feed cycles
    run_cmd(4, 0, 32'b1010, 1'b1);
    // LEN=1 and ignored LEN=0
    run_cmd(1, 0, 32'h0, 1'b1);
    pulse_start(0);
    repeat (3) @(negedge clk);
    // max length
    run_cmd((1 << CNT_W) - 1, 10, 32'h0, 1'b0);

    // back-to-back: new START in the P_VALID cycle
    pulse_start(3);
    feed(0, 32'h0, 1'b1);
    for (k = 0; k < 50 && cyc != m_pv_cyc; k++) @(negedge clk);
    check("b2b_reach", (cyc == m_pv_cyc), 1'b1);
    pulse_start(2);
    feed(20, 32'h0, 1'b0);
    wait_done();

    // asynchronous reset in the middle of DRAIN
    pulse_start(3);
    feed(0, 32'h0, 1'b1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1 reset_checks("async_rst");
    m_active = 1'b0;
    m_pv_cyc = -1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_cmd(3, 0, 32'h0, 1'b1);

`ifdef MAC_ABORT_EN
    // abort in the second feed cycle, then a clean LEN=2 command
    pulse_start(3);
    op_valid = 1'b1;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    op_valid = 1'b0;
    repeat (8) @(negedge clk);
    run_cmd(2, 0, 32'h0, 1'b1);
`endif

    // randomized commands, some launched in the previous P_VALID cycle
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(1) == 1 && m_pv_cyc >= cyc) begin
        for (k = 0; k < 50 && cyc != m_pv_cyc; k++) @(negedge clk);
      end
      pulse_start($urandom_range(1, 12));
      feed(30, 32'h0, 1'b0);
      if ($urandom_range(2) == 0) wait_done();
    end
    wait_done();
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Controller that sequences one DSP48A1-style slice through an N-term multiply-accumulate (dot product).
- Accepts a START command with a term count, then takes operand pairs over a valid/ready handshake.
- Drives a single pipeline clock enable and the OPMODE word into the slice.
- Tracks each term through the slice pipeline and pulses P_VALID when the final accumulated P is registered.
- Sits between the operand source (buffer/DMA front end) and the slice.

Parameters:
CNT_W, 8, width of term count LEN. Legal LEN range is 1 .. 2^CNT_W-1.
PIPE_LAT, 4, number of enabled slice register stages between operand capture and the P register, excluding P. Minimum 2.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
START  in  1  command strobe, sampled in IDLE only
LEN  in  CNT_W  term count, captured with START
OP_VALID  in  1  operand pair present on slice A/B inputs
OP_READY  out  1  controller accepts operand this cycle
CE_PIPE  out  1  clock enable for all slice pipeline registers, including P
OPMODE  out  8  slice OPMODE
BUSY  out  1  high from START acceptance until P_VALID cycle (inclusive)
P_VALID  out  1  one-cycle pulse: slice P holds the final sum

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; term counter, drain counter and all token stages cleared (valid=0, first=0, last=0).
- Reset values of outputs: OP_READY=0, CE_PIPE=0, BUSY=0, P_VALID=0, OPMODE=8'h08.
- Reset mid-operation aborts immediately. No P_VALID is issued for the aborted command.
- States: IDLE, FEED, DRAIN.
- IDLE -> FEED: on START=1 with LEN!=0. LEN is latched and the term counter is cleared.
- START with LEN==0 is ignored (stays IDLE, no pulse). START while not IDLE is ignored.
- FEED:
  - OP_READY=1. An accept occurs when OP_VALID=1 and OP_READY=1.
  - CE_PIPE=OP_VALID. A stall freezes the slice pipeline and the token pipe.
  - Each accept pushes a token into stage 0: valid=1, first=(count==0), last=(count==LEN-1). Count then increments.
- FEED -> DRAIN: on the accept of the last term.
- DRAIN:
  - OP_READY=0, CE_PIPE=1 for exactly PIPE_LAT cycles.
  - Bubble tokens (valid=0) enter stage 0.
  - DRAIN -> IDLE after the PIPE_LAT-th drain cycle.
- Token pipe: PIPE_LAT stages; shifts only on edges where CE_PIPE=1.
- OPMODE (combinational from token at stage PIPE_LAT-1, the term about to be captured into P):
  - valid & first: 8'h01 (X=M, Z=0; restarts the sum).
  - valid & !first: 8'h09 (X=M, Z=P; accumulate).
  - !valid: 8'h08 (X=0, Z=P; hold P).
  - Consequence: stale bubbles from a previous command cannot corrupt the new sum.
- P_VALID:
  - Registered pulse in the cycle after the edge that captures the last token into P.
  - Equals PIPE_LAT+1 cycles after the last accept cycle; stalls before the last accept do not add to this.
  - BUSY is high in the P_VALID cycle. The state is IDLE in that cycle, so a START in that cycle is accepted.
- BUSY = (state!=IDLE) | P_VALID.
- LEN=1: the first token is also last; P = A*B only.

Optional Feature:
Macro MAC_ABORT_EN.
- Defined: adds input port ABORT (1 bit).
  - ABORT=1 in FEED or DRAIN: next state IDLE, all tokens cleared, counter cleared, no P_VALID.
  - CE_PIPE=0 in the ABORT cycle.
  - ABORT has priority over accept, and over drain completion in the same cycle.
  - ABORT in IDLE is a no-op.
- Undefined: no ABORT port. A command always runs to P_VALID unless RST.

Test Plan:
1. PIPE_LAT=4, LEN=3, START at cycle 0, OP_VALID held high -> accepts in cycles 1,2,3; OPMODE 01,09,09 seen on the captures into P; DRAIN cycles 4-7 with CE_PIPE=1; P_VALID=1 only in cycle 8; BUSY 1..8.
2. LEN=4 with OP_VALID low in cycles 2 and 4 -> CE_PIPE=0 and tokens frozen in those cycles; last accept in cycle 6; P_VALID in cycle 11; slice P = sum of the 4 products.
3. LEN=1 -> single OPMODE 8'h01 capture; P_VALID exactly PIPE_LAT+1 cycles after the accept; START with LEN=0 -> no BUSY, no P_VALID.
4. Back-to-back: second START (LEN=2) in the first command's P_VALID cycle -> accepted; second result excludes the first sum (first OPMODE 8'h01); START pulsed mid-FEED -> ignored.
5. RST asserted asynchronously mid-DRAIN (between edges) -> outputs reach their reset values immediately; no P_VALID; next START behaves as in test 1.
6. With MAC_ABORT_EN, ABORT in cycle 2 of test 1 -> IDLE in cycle 3, CE_PIPE=0 in cycle 2, no P_VALID; a following LEN=2 command yields the correct 2-term sum.
